// File: rtl/dsp_mul_sequencer_pkg.sv
// Shared RV32M multiply definitions: op codes, sequencer states, operand sign rules.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package dsp_mul_sequencer_pkg;

  typedef enum logic [1:0] {
    MUL_OP_MUL    = 2'b00,
    MUL_OP_MULH   = 2'b01,
    MUL_OP_MULHSU = 2'b10,
    MUL_OP_MULHU  = 2'b11
  } mul_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_MUL  = 2'b01,
    S_FIX  = 2'b10,
    S_DONE = 2'b11
  } mul_state_t;

  // rs1 is treated as signed for MULH and MULHSU; MUL low word is sign-agnostic.
  function automatic logic op_a_signed(input mul_op_t op);
    return (op == MUL_OP_MULH) || (op == MUL_OP_MULHSU);
  endfunction

  // rs2 is treated as signed only for MULH.
  function automatic logic op_b_signed(input mul_op_t op);
    return (op == MUL_OP_MULH);
  endfunction

endpackage

// File: rtl/dsp_mul_sequencer_mul16u.sv
// Unregistered 16x16 unsigned multiplier, shaped to map onto one SB_MAC16 slice.
// Latency: combinational, product usable in the same cycle.
// Backpressure: none, pure function of inputs.
module dsp_mul16u (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [31:0] p
);

  // Full-width unsigned product; no input or output pipeline registers.
  always_comb begin
    p = {16'd0, a} * {16'd0, b};
  end

endmodule

// File: rtl/dsp_mul_sequencer.sv
// RV32M MUL/MULH/MULHSU/MULHU unit sequencing four 16x16 partial products through one DSP.
// Latency: start accepted in cycle T gives a one-cycle done pulse in T+6; next accept at T+7.
// Backpressure: ready is high only when idle; start while not ready is dropped, flush aborts.
module dsp_mul_sequencer
  import dsp_mul_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic        flush,
  output logic        ready,
  output logic        done,
  output logic [31:0] result
);

  mul_state_t  state;
  logic [1:0]  count;
  logic [31:0] a_abs;
  logic [31:0] b_abs;
  logic        neg;
  mul_op_t     op_q;
  logic [63:0] acc;

  logic [15:0] dsp_a;
  logic [15:0] dsp_b;
  logic [31:0] dsp_p;
  logic [63:0] pp_shift;
  logic [63:0] acc_fixed;
  logic        sign_a;
  logic        sign_b;
  logic [31:0] a_abs_nxt;
  logic [31:0] b_abs_nxt;

  // Magnitudes of the incoming operands; 0x80000000 negates to itself and is read as unsigned.
  always_comb begin
    sign_a    = op_a_signed(mul_op_t'(op)) & rs1[31];
    sign_b    = op_b_signed(mul_op_t'(op)) & rs2[31];
    a_abs_nxt = sign_a ? (~rs1 + 32'd1) : rs1;
    b_abs_nxt = sign_b ? (~rs2 + 32'd1) : rs2;
  end

  // Half-word selection depends on count alone: bit1 picks the A half, bit0 the B half.
  always_comb begin
    dsp_a = count[1] ? a_abs[31:16] : a_abs[15:0];
    dsp_b = count[0] ? b_abs[31:16] : b_abs[15:0];
  end

  dsp_mul16u u_dsp (
    .a (dsp_a),
    .b (dsp_b),
    .p (dsp_p)
  );

  // Align the partial product: lo*lo at 0, cross terms at 16, hi*hi at 32.
  always_comb begin
    pp_shift = 64'd0;
    case (count)
      2'd0:    pp_shift = {32'd0, dsp_p};
      2'd1:    pp_shift = {16'd0, dsp_p, 16'd0};
      2'd2:    pp_shift = {16'd0, dsp_p, 16'd0};
      default: pp_shift = {dsp_p, 32'd0};
    endcase
  end

  // Restore the sign of the magnitude product; negating zero yields zero.
  always_comb begin
    acc_fixed = neg ? (~acc + 64'd1) : acc;
  end

  // Sequencer FSM with registered ready/done/result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      ready  <= 1'b1;
      done   <= 1'b0;
      result <= 32'd0;
      acc    <= 64'd0;
      count  <= 2'd0;
      a_abs  <= 32'd0;
      b_abs  <= 32'd0;
      neg    <= 1'b0;
      op_q   <= MUL_OP_MUL;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && !flush) begin
            a_abs <= a_abs_nxt;
            b_abs <= b_abs_nxt;
            neg   <= sign_a ^ sign_b;
            op_q  <= mul_op_t'(op);
            acc   <= 64'd0;
            count <= 2'd0;
            ready <= 1'b0;
            state <= S_MUL;
          end
        end
        S_MUL: begin
          if (flush) begin
            ready <= 1'b1;
            state <= S_IDLE;
          end else begin
            acc   <= acc + pp_shift;
            count <= count + 2'd1;
            if (count == 2'd3) begin
              state <= S_FIX;
            end
          end
        end
        S_FIX: begin
          if (flush) begin
            ready <= 1'b1;
            state <= S_IDLE;
          end else begin
            acc    <= acc_fixed;
            result <= (op_q == MUL_OP_MUL) ? acc_fixed[31:0] : acc_fixed[63:32];
            done   <= 1'b1;
            state  <= S_DONE;
          end
        end
        default: begin
          // Result is already committed here, so a flush no longer cancels the pulse.
          ready <= 1'b1;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dsp_mul_sequencer.sv
module tb_dsp_mul_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        flush;
  logic        ready;
  logic        done;
  logic [31:0] result;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] last_res;

  always #5 clk = ~clk;

  dsp_mul_sequencer dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .rs1    (rs1),
    .rs2    (rs2),
    .flush  (flush),
    .ready  (ready),
    .done   (done),
    .result (result)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: extend each operand to 64 bits per op signedness, multiply mod 2^64.
  function automatic logic [31:0] ref_mul(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea;
    logic [63:0] eb;
    logic [63:0] p;
    ea = (o == 2'b01 || o == 2'b10) ? {{32{a[31]}}, a} : {32'd0, a};
    eb = (o == 2'b01) ? {{32{b[31]}}, b} : {32'd0, b};
    p  = ea * eb;
    return (o == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic count_dones(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      if (done) n++;
      tick();
    end
  endtask

  // Issue one op, check the T+6 latency and the result, return in IDLE.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    int k;
    k = 0;
    while (!ready && k < 20) begin
      tick();
      k++;
    end
    chk({tag, " ready"}, {63'd0, ready}, 64'd1);
    op = o; rs1 = a; rs2 = b; start = 1'b1;
    tick();
    start = 1'b0;
    k = 1;
    while (!done && k < 20) begin
      tick();
      k++;
    end
    chk({tag, " latency"}, 64'(k), 64'd6);
    chk({tag, " result"}, {32'd0, result}, {32'd0, exp});
    last_res = exp;
    tick();
  endtask

  typedef struct {
    logic [1:0]  o;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[13];

  initial begin
    int n;
    logic [31:0] va[35];
    logic [31:0] vb[35];
    logic [1:0]  vo[35];
    logic [1:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;

    vecs[0]  = '{2'b00, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB};
    vecs[1]  = '{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
    vecs[2]  = '{2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[3]  = '{2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[4]  = '{2'b01, 32'h0000_0000, 32'h8000_0000, 32'h0000_0000};
    vecs[5]  = '{2'b00, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000};
    vecs[6]  = '{2'b11, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001};
    vecs[7]  = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
    vecs[8]  = '{2'b10, 32'h8000_0000, 32'h8000_0000, 32'hC000_0000};
    vecs[9]  = '{2'b01, 32'h8000_0000, 32'h7FFF_FFFF, 32'hC000_0000};
    vecs[10] = '{2'b00, 32'h0000_FFFF, 32'h0000_FFFF, 32'hFFFE_0001};
    vecs[11] = '{2'b11, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001};
    vecs[12] = '{2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF};

    reset = 1'b1; start = 1'b0; flush = 1'b0; op = 2'b00; rs1 = '0; rs2 = '0;
    last_res = 32'd0;
    tick(); tick(); tick();
    chk("reset ready", {63'd0, ready}, 64'd1);
    chk("reset done", {63'd0, done}, 64'd0);
    chk("reset result", {32'd0, result}, 64'd0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 13; i++)
      run_op($sformatf("vec%0d", i), vecs[i].o, vecs[i].a, vecs[i].b, vecs[i].exp);

    // start held high every cycle: accepts at c%7==0, dones at c%7==6
    for (int c = 0; c < 35; c++) begin
      va[c] = $urandom; vb[c] = $urandom; vo[c] = 2'(c % 4);
    end
    for (int c = 0; c < 35; c++) begin
      op = vo[c]; rs1 = va[c]; rs2 = vb[c]; start = 1'b1;
      chk($sformatf("evc ready c%0d", c), {63'd0, ready}, 64'((c % 7) == 0));
      chk($sformatf("evc done c%0d", c), {63'd0, done}, 64'((c % 7) == 6));
      if ((c % 7) == 6) begin
        last_res = ref_mul(vo[c-6], va[c-6], vb[c-6]);
        chk($sformatf("evc result c%0d", c), {32'd0, result}, {32'd0, last_res});
      end
      tick();
    end
    start = 1'b0;
    tick();

    // flush during MUL (T+2)
    op = 2'b01; rs1 = 32'h1234_5678; rs2 = 32'h8765_4321; start = 1'b1;
    tick(); start = 1'b0;
    tick(); flush = 1'b1;
    tick(); flush = 1'b0;
    chk("flush mul ready", {63'd0, ready}, 64'd1);
    count_dones(10, n);
    chk("flush mul no done", 64'(n), 64'd0);
    chk("flush mul result held", {32'd0, result}, {32'd0, last_res});

    // flush during FIX (T+5)
    op = 2'b11; rs1 = 32'hDEAD_BEEF; rs2 = 32'h0BAD_F00D; start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick(); tick(); tick();
    flush = 1'b1;
    tick(); flush = 1'b0;
    chk("flush fix ready", {63'd0, ready}, 64'd1);
    count_dones(10, n);
    chk("flush fix no done", 64'(n), 64'd0);
    chk("flush fix result held", {32'd0, result}, {32'd0, last_res});

    // flush together with start in IDLE: not accepted
    op = 2'b00; rs1 = 32'd3; rs2 = 32'd5; start = 1'b1; flush = 1'b1;
    tick(); start = 1'b0; flush = 1'b0;
    chk("flush start ready", {63'd0, ready}, 64'd1);
    count_dones(10, n);
    chk("flush start no done", 64'(n), 64'd0);

    // flush in DONE: pulse still delivered
    op = 2'b00; rs1 = 32'd3; rs2 = 32'd5; start = 1'b1;
    tick(); start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    flush = 1'b1;
    chk("flush done pulse", {63'd0, done}, 64'd1);
    chk("flush done result", {32'd0, result}, 64'd15);
    tick(); flush = 1'b0;
    last_res = 32'd15;

    // reset mid-operation (T+3)
    op = 2'b11; rs1 = 32'hFFFF_0000; rs2 = 32'h0000_FFFF; start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick(); reset = 1'b0;
    chk("rst mid ready", {63'd0, ready}, 64'd1);
    chk("rst mid result", {32'd0, result}, 64'd0);
    count_dones(10, n);
    chk("rst mid no done", 64'(n), 64'd0);

    // random regression against the reference model
    for (int i = 0; i < 1500; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      if (i % 50 == 0) ra = 32'h8000_0000;
      if (i % 70 == 0) rb = 32'hFFFF_FFFF;
      run_op($sformatf("rand%0d", i), ro, ra, rb, ref_mul(ro, ra, rb));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
